// File: rtl/mipi_delay_cal_if.sv
// Control/result bundle between a calibration master and the delay-line
// calibrator, plus the lane sample and the tap-code write path.
interface mipi_delay_cal_if #(
   parameter int P_DELAY_NBIT = 5,
   parameter int P_DATA_NBIT  = 8
);
   logic                    start;
   logic [P_DATA_NBIT-1:0]  pattern;
   logic [P_DATA_NBIT-1:0]  rx_data;
   logic [P_DELAY_NBIT-1:0] delay;
   logic                    delay_we;
   logic                    busy;
   logic                    done;
   logic                    fail;
   logic [P_DELAY_NBIT-1:0] win_lo;
   logic [P_DELAY_NBIT-1:0] win_hi;

   modport master (
      output start, pattern, rx_data,
      input  delay, delay_we, busy, done, fail, win_lo, win_hi
   );

   modport slave (
      input  start, pattern, rx_data,
      output delay, delay_we, busy, done, fail, win_lo, win_hi
   );
endinterface

// File: rtl/mipi_delay_cal.sv
// Sweeps every delay tap, finds the longest contiguous run of taps that sample
// the training word cleanly, and parks the delay line at the centre of that run.
module mipi_delay_cal #(
   parameter int P_DELAY_NBIT = 5,
   parameter int P_DATA_NBIT  = 8,
   parameter int P_SETTLE     = 8,
   parameter int P_CHECK      = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   mipi_delay_cal_if.slave cal
);

   localparam int CNT_MAX  = (P_SETTLE > P_CHECK) ? P_SETTLE : P_CHECK;
   localparam int CNT_NBIT = $clog2(CNT_MAX);
   localparam int LEN_NBIT = P_DELAY_NBIT + 1;

   localparam logic [CNT_NBIT-1:0]     STROBE_LAST = CNT_NBIT'(1);
   localparam logic [CNT_NBIT-1:0]     SETTLE_LAST = CNT_NBIT'(P_SETTLE - 1);
   localparam logic [CNT_NBIT-1:0]     CHECK_LAST  = CNT_NBIT'(P_CHECK - 1);
   localparam logic [P_DELAY_NBIT-1:0] TAP_LAST    = '1;
   localparam logic [P_DELAY_NBIT-1:0] TAP_MID     = {1'b1, {(P_DELAY_NBIT-1){1'b0}}};

   typedef enum logic [3:0] {
      IDLE,
      SET,
      SETTLE,
      CHECK,
      NEXT,
      CALC,
      APPLY,
      APPLY_WAIT,
      DONE
   } state_t;

   state_t                  state_reg,      state_next;
   logic [CNT_NBIT-1:0]     cnt_reg,        cnt_next;
   logic [P_DELAY_NBIT-1:0] tap_reg,        tap_next;
   logic                    pass_reg,       pass_next;
   logic [P_DELAY_NBIT-1:0] run_start_reg,  run_start_next;
   logic [LEN_NBIT-1:0]     run_len_reg,    run_len_next;
   logic [P_DELAY_NBIT-1:0] best_start_reg, best_start_next;
   logic [LEN_NBIT-1:0]     best_len_reg,   best_len_next;
   logic [P_DELAY_NBIT-1:0] delay_reg,      delay_next;
   logic [P_DELAY_NBIT-1:0] win_lo_reg,     win_lo_next;
   logic [P_DELAY_NBIT-1:0] win_hi_reg,     win_hi_next;
   logic                    done_reg,       done_next;
   logic                    fail_reg,       fail_next;

   logic [P_DELAY_NBIT-1:0] cur_start;
   logic [LEN_NBIT-1:0]     cur_len;
   logic [LEN_NBIT-1:0]     len_m1;
   logic [P_DATA_NBIT-1:0]  bit_match;
   logic                    word_match;

   genvar gi;
   generate
      for (gi = 0; gi < P_DATA_NBIT; gi++) begin : g_match
         assign bit_match[gi] = (cal.rx_data[gi] == cal.pattern[gi]);
      end
   endgenerate

   assign word_match = &bit_match;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         tap_reg        <= '0;
         pass_reg       <= 1'b0;
         run_start_reg  <= '0;
         run_len_reg    <= '0;
         best_start_reg <= '0;
         best_len_reg   <= '0;
         delay_reg      <= '0;
         win_lo_reg     <= '0;
         win_hi_reg     <= '0;
         done_reg       <= 1'b0;
         fail_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         tap_reg        <= tap_next;
         pass_reg       <= pass_next;
         run_start_reg  <= run_start_next;
         run_len_reg    <= run_len_next;
         best_start_reg <= best_start_next;
         best_len_reg   <= best_len_next;
         delay_reg      <= delay_next;
         win_lo_reg     <= win_lo_next;
         win_hi_reg     <= win_hi_next;
         done_reg       <= done_next;
         fail_reg       <= fail_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      tap_next        = tap_reg;
      pass_next       = pass_reg;
      run_start_next  = run_start_reg;
      run_len_next    = run_len_reg;
      best_start_next = best_start_reg;
      best_len_next   = best_len_reg;
      delay_next      = delay_reg;
      win_lo_next     = win_lo_reg;
      win_hi_next     = win_hi_reg;
      done_next       = done_reg;
      fail_next       = fail_reg;
      cur_start       = run_start_reg;
      cur_len         = run_len_reg;
      len_m1          = best_len_reg - LEN_NBIT'(1);

      case (state_reg)
         IDLE, DONE: begin
            if (cal.start) begin
               done_next       = 1'b0;
               fail_next       = 1'b0;
               win_lo_next     = '0;
               win_hi_next     = '0;
               tap_next        = '0;
               run_start_next  = '0;
               run_len_next    = '0;
               best_start_next = '0;
               best_len_next   = '0;
               cnt_next        = '0;
               delay_next      = '0;
               state_next      = SET;
            end
         end

         SET: begin
            if (cnt_reg == STROBE_LAST) begin
               cnt_next   = '0;
               state_next = SETTLE;
            end else begin
               cnt_next = cnt_reg + CNT_NBIT'(1);
            end
         end

         SETTLE: begin
            if (cnt_reg == SETTLE_LAST) begin
               cnt_next   = '0;
               pass_next  = 1'b1;
               state_next = CHECK;
            end else begin
               cnt_next = cnt_reg + CNT_NBIT'(1);
            end
         end

         CHECK: begin
            pass_next = pass_reg & word_match;
            if (cnt_reg == CHECK_LAST) begin
               cnt_next   = '0;
               state_next = NEXT;
            end else begin
               cnt_next = cnt_reg + CNT_NBIT'(1);
            end
         end

         NEXT: begin
            // A zero run length means no run is currently open.
            if (pass_reg) begin
               if (run_len_reg != '0) begin
                  cur_len = run_len_reg + LEN_NBIT'(1);
               end else begin
                  cur_start = tap_reg;
                  cur_len   = LEN_NBIT'(1);
               end
            end
            if (!pass_reg || (tap_reg == TAP_LAST)) begin
               if (cur_len > best_len_reg) begin
                  best_start_next = cur_start;
                  best_len_next   = cur_len;
               end
               run_start_next = '0;
               run_len_next   = '0;
            end else begin
               run_start_next = cur_start;
               run_len_next   = cur_len;
            end
            if (tap_reg == TAP_LAST) begin
               state_next = CALC;
            end else begin
               tap_next   = tap_reg + P_DELAY_NBIT'(1);
               delay_next = tap_reg + P_DELAY_NBIT'(1);
               state_next = SET;
            end
         end

         CALC: begin
            cnt_next   = '0;
            state_next = APPLY;
            if (best_len_reg == '0) begin
               fail_next   = 1'b1;
               win_lo_next = '0;
               win_hi_next = '0;
               delay_next  = TAP_MID;
            end else begin
               win_lo_next = best_start_reg;
               win_hi_next = best_start_reg + len_m1[P_DELAY_NBIT-1:0];
               delay_next  = best_start_reg + len_m1[LEN_NBIT-1:1];
            end
         end

         APPLY: begin
            if (cnt_reg == STROBE_LAST) begin
               cnt_next   = '0;
               state_next = APPLY_WAIT;
            end else begin
               cnt_next = cnt_reg + CNT_NBIT'(1);
            end
         end

         APPLY_WAIT: begin
            if (cnt_reg == SETTLE_LAST) begin
               cnt_next   = '0;
               done_next  = 1'b1;
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg + CNT_NBIT'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Strobe and busy are decoded straight from the state register so reset
   // drops them in the same instant it forces IDLE.
   assign cal.delay_we = (state_reg == SET) || (state_reg == APPLY);
   assign cal.busy     = (state_reg != IDLE) && (state_reg != DONE);
   assign cal.delay    = delay_reg;
   assign cal.done     = done_reg;
   assign cal.fail     = fail_reg;
   assign cal.win_lo   = win_lo_reg;
   assign cal.win_hi   = win_hi_reg;

endmodule
